// File: rtl/ipf_pkg.sv
// ipf_pkg: shared FSM states, LCU size codes, prm_q field positions and address helpers for the LCU feeder.
package ipf_pkg;
  localparam int IMG_LOG2 = 7;
  localparam int TYPE_LSB = 22;
  localparam int BAND_LSB = 17;
  localparam int WO_BIT   = 16;
  localparam int OFF_LSB  = 0;
  typedef enum logic [2:0] {IDLE, PFETCH, PCAP, STREAM, DONE} state_t;
  typedef enum logic [1:0] {SZ_16, SZ_32, SZ_64, SZ_RSV} lcu_size_t;
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (s == SZ_RSV) ? SZ_64 : s;
  endfunction
  function automatic logic [2*IMG_LOG2-1:0] pix_addr(input logic [1:0] s, input logic [2:0] x,
                                                     input logic [2:0] y, input logic [5:0] r,
                                                     input logic [5:0] c);
    logic [IMG_LOG2-1:0] row, col;
    row = ({4'b0, y} << (4 + s)) | {1'b0, r};
    col = ({4'b0, x} << (4 + s)) | {1'b0, c};
    return {row, col};
  endfunction
endpackage

// File: rtl/ipf_lcu_addr_gen.sv
// ipf_lcu_addr_gen: pixel and LCU counters plus image SRAM address for the feeder.
module ipf_lcu_addr_gen
  import ipf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  input  logic                  freeze,
  input  logic [1:0]            size,
  output logic [2*IMG_LOG2-1:0] img_addr,
  output logic [2:0]            lcu_x,
  output logic [2:0]            lcu_y,
  output logic                  last_pix,
  output logic                  last_lcu
);
  logic [5:0] r, c, r_n, c_n, s_max;
  logic [2:0] x_n, y_n, n_max;
  logic adv, last_c, last_x;
  // Counters track the pixel whose data is on img_q; a step already requests the next one.
  always_comb begin
    s_max = 6'((7'd16 << size) - 7'd1);
    n_max = 3'((4'd8 >> size) - 4'd1);
    adv = step && !freeze;
    last_c = c == s_max;
    last_x = lcu_x == n_max;
    last_pix = last_c && r == s_max;
    last_lcu = last_x && lcu_y == n_max;
    c_n = last_c ? '0 : c + 6'd1;
    r_n = !last_c ? r : last_pix ? '0 : r + 6'd1;
    x_n = !last_pix ? lcu_x : last_x ? '0 : lcu_x + 3'd1;
    y_n = !(last_pix && last_x) ? lcu_y : last_lcu ? '0 : lcu_y + 3'd1;
    img_addr = adv ? pix_addr(size, x_n, y_n, r_n, c_n) : pix_addr(size, lcu_x, lcu_y, r, c);
  end
  always_ff @(posedge clk)
    if (reset || clear) {r, c, lcu_x, lcu_y} <= '0;
    else if (adv) {r, c, lcu_x, lcu_y} <= {r_n, c_n, x_n, y_n};
endmodule

// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder: walks a 128x128 image LCU by LCU, streaming pixels and per-LCU params to the filter.
// Optional IPF_FEED_STALL_CNT_EN adds stall_cnt, counting back-pressured STREAM cycles.
module ipf_lcu_feeder
  import ipf_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PARAM_AW = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cfg_size,
  input  logic                  busy,
  output logic [2*IMG_LOG2-1:0] img_addr,
  input  logic [DATA_W-1:0]     img_q,
  output logic [PARAM_AW-1:0]   prm_addr,
  input  logic [23:0]           prm_q,
  output logic                  in_en,
  output logic [DATA_W-1:0]     din,
  output logic [1:0]            ipf_type,
  output logic [4:0]            ipf_band_pos,
  output logic                  ipf_wo_class,
  output logic [15:0]           ipf_offset,
  output logic [2:0]            lcu_x,
  output logic [2:0]            lcu_y,
  output logic [1:0]            lcu_size,
`ifdef IPF_FEED_STALL_CNT_EN
  output logic                  frame_done,
  output logic [15:0]           stall_cnt
`else
  output logic                  frame_done
`endif
);
  state_t state, state_n;
  logic [1:0] size_e;
  logic [2:0] gx, gy;
  logic go, cap, last_pix, last_lcu;
  assign size_e = eff_size(lcu_size);
  assign go = state == IDLE && start;
  assign cap = state == PCAP && !busy;
  ipf_lcu_addr_gen u_addr (
    .clk(clk), .reset(reset), .clear(go), .step(state == STREAM), .freeze(busy),
    .size(size_e), .img_addr(img_addr), .lcu_x(gx), .lcu_y(gy),
    .last_pix(last_pix), .last_lcu(last_lcu)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? PFETCH : IDLE;
      PFETCH:  state_n = busy ? PFETCH : PCAP;
      PCAP:    state_n = busy ? PCAP : STREAM;
      STREAM:  state_n = (busy || !last_pix) ? STREAM : last_lcu ? DONE : PFETCH;
      default: state_n = IDLE;
    endcase
    in_en = state == STREAM && !busy;
    din = state == STREAM ? img_q : '0;
    frame_done = state == DONE;
    prm_addr = PARAM_AW'(({3'b0, gy} << (2'd3 - size_e)) | {3'b0, gx});
  end
  // Params and LCU coordinates are captured together so they change with the first pixel.
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      lcu_size <= SZ_16;
      {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} <= '0;
      {lcu_x, lcu_y} <= '0;
    end else begin
      state <= state_n;
      if (go) lcu_size <= cfg_size;
      if (cap) begin
        ipf_type <= prm_q[TYPE_LSB +: 2];
        ipf_band_pos <= prm_q[BAND_LSB +: 5];
        ipf_wo_class <= prm_q[WO_BIT];
        ipf_offset <= prm_q[OFF_LSB +: 16];
        {lcu_x, lcu_y} <= {gx, gy};
      end
    end
`ifdef IPF_FEED_STALL_CNT_EN
  always_ff @(posedge clk)
    if (reset || go) stall_cnt <= '0;
    else if (state == STREAM && busy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// tb_ipf_lcu_feeder: directed checks of the LCU feeder against SRAM models and a raster-order address model.
module tb_ipf_lcu_feeder;
  logic clk = 0, reset = 1, start = 0, busy = 0;
  logic [1:0] cfg_size = 0;
  logic [13:0] img_addr;
  logic [7:0] img_q = 0;
  logic [5:0] prm_addr;
  logic [23:0] prm_q = 0;
  logic in_en, ipf_wo_class, frame_done;
  logic [7:0] din;
  logic [1:0] ipf_type, lcu_size;
  logic [4:0] ipf_band_pos;
  logic [15:0] ipf_offset;
  logic [2:0] lcu_x, lcu_y;
`ifdef IPF_FEED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  logic [23:0] prm_mem [64];
  int checks = 0, errors = 0;
  int npix, nbad, nfd, first_t, extra_en, n, t;
  logic [13:0] prev_addr, w_addr;
  logic [5:0] prm_t1;
  logic [1:0] w_type, w_size;
  logic [4:0] w_band;
  logic w_wo;
  logic [15:0] w_off, w_stall;
  logic [2:0] w_x, w_y;

  ipf_lcu_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_size(cfg_size), .busy(busy),
    .img_addr(img_addr), .img_q(img_q), .prm_addr(prm_addr), .prm_q(prm_q),
    .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
    .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset), .lcu_x(lcu_x), .lcu_y(lcu_y),
`ifdef IPF_FEED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .lcu_size(lcu_size), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [13:0] a);
    return 8'(a[6:0] + 3 * a[13:7]);
  endfunction

  function automatic logic [13:0] exp_addr(input int sz, input int k);
    int s, nl, l, p;
    s = 16 << sz;
    nl = 128 / s;
    l = k / (s * s);
    p = k % (s * s);
    return {7'((l / nl) * s + p / s), 7'((l % nl) * s + p % s)};
  endfunction

  always @(posedge clk) begin
    img_q <= pix(img_addr);
    prm_q <= prm_mem[prm_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input logic [1:0] sz, input int watch, input int b0, input int blen,
                           input int rs_t);
    int tt = 0, after = -1;
    npix = 0; nbad = 0; nfd = 0; first_t = -1; extra_en = 0; w_stall = '1;
    @(negedge clk);
    cfg_size = sz;
    start = 1;
    #1;
    prev_addr = img_addr;
    while (tt < 20000 && after < 5) begin
      @(negedge clk);
      tt++;
      start = (tt == rs_t);
      busy = (tt >= b0 && tt < b0 + blen);
      if (tt == 10) cfg_size = 2'd0;
      #1;
      if (tt == 1) prm_t1 = prm_addr;
      if (after >= 0) after++;
      if (in_en && after >= 0) extra_en++;
      else if (in_en) begin
        if (first_t < 0) first_t = tt;
        if (din !== pix(exp_addr(sz, npix)) || prev_addr !== exp_addr(sz, npix)) nbad++;
        if (npix == watch) begin
          w_addr = prev_addr; w_type = ipf_type; w_band = ipf_band_pos; w_wo = ipf_wo_class;
          w_off = ipf_offset; w_x = lcu_x; w_y = lcu_y; w_size = lcu_size;
        end
        npix++;
      end
      if (frame_done) begin
        nfd++;
        if (after < 0) begin
          after = 0;
`ifdef IPF_FEED_STALL_CNT_EN
          w_stall = stall_cnt;
`endif
        end
      end
      prev_addr = img_addr;
    end
    busy = 0;
    start = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) prm_mem[i] = 24'h400000 | 24'(i);
    prm_mem[3] = 24'hA51234;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_en", in_en, 0);
    check("rst_img_addr", img_addr, 0);
    check("rst_prm_addr", prm_addr, 0);
    check("rst_type", ipf_type, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_lcu_size", lcu_size, 0);
    // Abort a frame with reset after 100 pixels.
    @(negedge clk);
    reset = 0; cfg_size = 0; start = 1;
    n = 0; t = 0;
    do begin
      @(negedge clk);
      start = 0; t++;
      #1;
      if (in_en) n++;
    end while (n < 100 && t < 500);
    check("pre_rst_pix", n, 100);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_mid_in_en", in_en, 0);
    check("rst_mid_img_addr", img_addr, 0);
    check("rst_mid_prm_addr", prm_addr, 0);
    check("rst_mid_type", ipf_type, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (in_en) n++;
    end
    check("post_rst_quiet", n, 0);
    // Full 16x16 frame after the restart.
    run_frame(2'd0, 256, 0, 0, 0);
    check("s16_prm_t1", prm_t1, 0);
    check("s16_first_t", first_t, 3);
    check("s16_npix", npix, 16384);
    check("s16_bad", nbad, 0);
    check("s16_done", nfd, 1);
    check("s16_extra", extra_en, 0);
    check("s16_lcu1_addr", w_addr, 14'h0010);
    check("s16_lcu1_off", w_off, 16'h0001);
    check("s16_lcu1_type", w_type, 2'b01);
    check("s16_lcu1_x", w_x, 1);
    check("s16_lcu1_y", w_y, 0);
    // 64x64 frame with a 37-cycle stall inside LCU 0.
    run_frame(2'd2, 12288, 500, 37, 0);
    check("s64_first_t", first_t, 3);
    check("s64_npix", npix, 16384);
    check("s64_bad", nbad, 0);
    check("s64_done", nfd, 1);
    check("s64_addr", w_addr, 14'h2040);
    check("s64_type", w_type, 2'b10);
    check("s64_band", w_band, 5'd18);
    check("s64_wo", w_wo, 1'b1);
    check("s64_off", w_off, 16'h1234);
    check("s64_x", w_x, 1);
    check("s64_y", w_y, 1);
    check("s64_size", w_size, 2);
`ifdef IPF_FEED_STALL_CNT_EN
    check("s64_stall_cnt", w_stall, 37);
`endif
    // 32x32 frame: 5-cycle stall mid-row and an ignored second start.
    run_frame(2'd1, 5120, 43, 5, 200);
    check("s32_npix", npix, 16384);
    check("s32_bad", nbad, 0);
    check("s32_done", nfd, 1);
    check("s32_extra", extra_en, 0);
    check("s32_addr", w_addr, 14'h1020);
    check("s32_off", w_off, 16'h0005);
    check("s32_x", w_x, 1);
    check("s32_y", w_y, 1);
    check("s32_size", w_size, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
